universal_shift_reg: RTL and testbench
======================================

# universal_shift_reg

Synchronous N-bit universal shift register with four modes: hold, shift right, shift left and parallel load. A 2-bit select chooses the mode. Each shift direction has its own serial input. It is a general-purpose datapath primitive for serializers, deserializers and rotate/shift staging. The output is the register state itself, with no combinational path from the inputs.

## Interface
- `WIDTH`, default 4: register width in bits. Must be ≥ 2.
- `clk`  input  1: sole clock; all state updates on the rising edge.
- `rst`  input  1: asynchronous, active-low reset (asserted when 0).
- `select`  input  2: mode select; encoding below.
- `p_din`  input  WIDTH: parallel load data.
- `s_left_din`  input  1: serial input used during shift left; enters at bit 0.
- `s_right_din`  input  1: serial input used during shift right; enters at bit WIDTH-1.
- `p_dout`  output  WIDTH: current register contents.

## Operation
- Reset:
  - While `rst`=0, `p_dout` is forced to 0 immediately, without waiting for a clock edge.
  - Reset takes priority over every mode.
- Mode encoding and next state on each rising `clk` with `rst`=1:
  - `2'b00` hold: `p_dout` keeps its value.
  - `2'b01` shift right: `p_dout <= {s_right_din, p_dout[WIDTH-1:1]}`. The LSB is discarded.
  - `2'b10` shift left: `p_dout <= {p_dout[WIDTH-2:0], s_left_din}`. The MSB is discarded.
  - `2'b11` parallel load: `p_dout <= p_din`.
- Unused inputs are ignored:
  - `p_din` is ignored except in load mode.
  - `s_left_din` and `s_right_din` are ignored except in their own shift mode.
- X/Z on `select` need not be handled.
- The register is fully determined by the four codes; there is no default case that changes state.
- No rotate mode: a shifted-out bit never re-enters unless it is driven back through a serial input externally.

## Timing
- Latency is one clock. A mode applied before edge k is visible on `p_dout` right after edge k.
- `p_dout` is driven directly by flops; there is no combinational path from any input to the output.
- Reset assertion mid-shift clears the register at once. Shifted data is lost.
- Reset deassertion is clean. The first edge with `rst`=1 applies the current `select` to a state of 0.
- Mode changes between consecutive edges are allowed.
- Every cycle is independent. There is no handshake and no busy state.
- `select`, `p_din` and the serial inputs must meet setup/hold relative to `clk`.

## Structure
- Shared package `usr_pkg`:
  - Select encoding constants: `USR_HOLD`=2'b00, `USR_SHR`=2'b01, `USR_SHL`=2'b10, `USR_LOAD`=2'b11.
  - Default width constant.
- One flat module is natural: a next-state mux feeding a WIDTH-bit register with async clear.
- An optional per-bit cell `usr_bit_cell` (4:1 mux plus flop, with neighbour taps) may be generated WIDTH times. The top module wires the boundary taps to `s_left_din` and `s_right_din`.
- The implementation, including parameter checks and optional assertions, should land in the 120–400 line range.

## Test plan
- Reset: hold `rst`=0 with arbitrary `select`/`p_din` → `p_dout`=0000 immediately, and it stays 0 across clock edges.
- Load then hold:
  - `select`=11, `p_din`=1010, one edge → `p_dout`=1010.
  - `select`=00, one edge → stays 1010.
- Shift left fill: from 1010, `select`=10, `s_left_din`=1, four edges → 0101, 1011, 0111, 1111.
- Shift right drain: from 1111, `select`=01, `s_right_din`=0, four edges → 0111, 0011, 0001, 0000. Then `select`=00 for 100 edges → stays 0000.
- Serial inputs on opposite ends:
  - Load 0000, shift right with `s_right_din`=1, one edge → 1000.
  - Load 0000, shift left with `s_left_din`=1, one edge → 0001.
  - In each case, toggling the other serial input has no effect.
- Async reset mid-operation: load 1111, assert `rst`=0 between edges → `p_dout`=0000 before the next edge. Release `rst`, then shift left with `s_left_din`=1 → 0001.

Source files
------------

// File: rtl/usr_pkg.sv
// rtl/usr_pkg.sv - shared constants for the universal shift register
//   USR_HOLD/USR_SHR/USR_SHL/USR_LOAD : select encodings
//   USR_DEFAULT_WIDTH                 : default register width
package usr_pkg;

    localparam logic [1:0] USR_HOLD = 2'b00;
    localparam logic [1:0] USR_SHR  = 2'b01;
    localparam logic [1:0] USR_SHL  = 2'b10;
    localparam logic [1:0] USR_LOAD = 2'b11;

    localparam int USR_DEFAULT_WIDTH = 4;

endpackage

// File: rtl/usr_bit_cell.sv
// rtl/usr_bit_cell.sv - one bit of the universal shift register (4:1 mux + flop)
//   clk        : clock, rising edge
//   rst        : asynchronous clear, active low
//   select     : mode select (hold / shift right / shift left / load)
//   load_bit   : parallel-load data for this bit
//   left_tap   : value entering during shift left (lower neighbour or serial input)
//   right_tap  : value entering during shift right (upper neighbour or serial input)
//   q          : stored bit
module usr_bit_cell
    import usr_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] select,
    input  logic       load_bit,
    input  logic       left_tap,
    input  logic       right_tap,
    output logic       q
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= 1'b0;
        end else begin
            // All four codes are listed, so nothing falls through to a default.
            case (select)
                USR_HOLD: q <= q;
                USR_SHR:  q <= right_tap;
                USR_SHL:  q <= left_tap;
                USR_LOAD: q <= load_bit;
            endcase
        end
    end

endmodule

// File: rtl/universal_shift_reg.sv
// rtl/universal_shift_reg.sv - N-bit universal shift register (hold, shr, shl, load)
//   WIDTH       : register width, at least 2
//   clk         : clock, rising edge
//   rst         : asynchronous clear, active low
//   select      : 00 hold, 01 shift right, 10 shift left, 11 parallel load
//   p_din       : parallel load data
//   s_left_din  : serial input for shift left, enters at bit 0
//   s_right_din : serial input for shift right, enters at bit WIDTH-1
//   p_dout      : register contents, driven straight from the flops
module universal_shift_reg
    import usr_pkg::*;
#(
    parameter int WIDTH = USR_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       select,
    input  logic [WIDTH-1:0] p_din,
    input  logic             s_left_din,
    input  logic             s_right_din,
    output logic [WIDTH-1:0] p_dout
);

    if (WIDTH < 2) begin : g_bad_width
        $error("universal_shift_reg: WIDTH must be at least 2");
    end

    // Neighbour taps with the serial inputs spliced in at the ends:
    // bit i takes bit i-1 on shift left and bit i+1 on shift right.
    logic [WIDTH-1:0] left_taps;
    logic [WIDTH-1:0] right_taps;

    assign left_taps  = {p_dout[WIDTH-2:0], s_left_din};
    assign right_taps = {s_right_din, p_dout[WIDTH-1:1]};

    for (genvar i = 0; i < WIDTH; i++) begin : g_bits
        usr_bit_cell u_cell (
            .clk       (clk),
            .rst       (rst),
            .select    (select),
            .load_bit  (p_din[i]),
            .left_tap  (left_taps[i]),
            .right_tap (right_taps[i]),
            .q         (p_dout[i])
        );
    end

endmodule

// File: tb/tb_universal_shift_reg.sv
// tb/tb_universal_shift_reg.sv - directed self-checking bench for universal_shift_reg
module tb_universal_shift_reg;

    logic       clk;
    logic       rst;
    logic [1:0] select;
    logic [3:0] p_din;
    logic       s_left_din;
    logic       s_right_din;
    logic [3:0] p_dout;

    int n_checks;
    int n_fails;

    universal_shift_reg #(.WIDTH(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .select      (select),
        .p_din       (p_din),
        .s_left_din  (s_left_din),
        .s_right_din (s_right_din),
        .p_dout      (p_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [3:0] got, input logic [3:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    // Advance one rising edge and land 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [3:0] shl_exp [4];
    logic [3:0] shr_exp [4];

    initial begin
        n_checks    = 0;
        n_fails     = 0;
        shl_exp     = '{4'b0101, 4'b1011, 4'b0111, 4'b1111};
        shr_exp     = '{4'b0111, 4'b0011, 4'b0001, 4'b0000};

        rst         = 1'b1;
        select      = 2'b11;
        p_din       = 4'b1111;
        s_left_din  = 1'b1;
        s_right_din = 1'b1;

        // Reset before any clock edge, then held across edges.
        #1 rst = 1'b0;
        #1 check_eq("reset_immediate", p_dout, 4'b0000);
        step();
        check_eq("reset_edge1", p_dout, 4'b0000);
        step();
        check_eq("reset_edge2", p_dout, 4'b0000);

        // Load then hold.
        rst    = 1'b1;
        select = 2'b11;
        p_din  = 4'b1010;
        step();
        check_eq("load_1010", p_dout, 4'b1010);
        select = 2'b00;
        p_din  = 4'b0101;
        step();
        check_eq("hold_1010", p_dout, 4'b1010);

        // Shift left fill with ones.
        select      = 2'b10;
        s_left_din  = 1'b1;
        s_right_din = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            check_eq($sformatf("shl_fill_%0d", i), p_dout, shl_exp[i]);
        end

        // Shift right drain with zeros.
        select      = 2'b01;
        s_right_din = 1'b0;
        s_left_din  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check_eq($sformatf("shr_drain_%0d", i), p_dout, shr_exp[i]);
        end

        // Long hold while the unused inputs wiggle.
        select = 2'b00;
        for (int i = 0; i < 100; i++) begin
            p_din       = 4'(i);
            s_left_din  = i[0];
            s_right_din = i[1];
            step();
        end
        check_eq("hold_100", p_dout, 4'b0000);

        // Serial right input enters at the MSB; left input ignored.
        select = 2'b11; p_din = 4'b0000; step();
        select = 2'b01; s_right_din = 1'b1; s_left_din = 1'b0; p_din = 4'b1111; step();
        check_eq("shr_msb_sl0", p_dout, 4'b1000);
        select = 2'b11; p_din = 4'b0000; step();
        select = 2'b01; s_right_din = 1'b1; s_left_din = 1'b1; step();
        check_eq("shr_msb_sl1", p_dout, 4'b1000);
        s_right_din = 1'b0; step();
        check_eq("shr_next", p_dout, 4'b0100);

        // Serial left input enters at the LSB; right input ignored.
        select = 2'b11; p_din = 4'b0000; step();
        select = 2'b10; s_left_din = 1'b1; s_right_din = 1'b0; p_din = 4'b1111; step();
        check_eq("shl_lsb_sr0", p_dout, 4'b0001);
        select = 2'b11; p_din = 4'b0000; step();
        select = 2'b10; s_left_din = 1'b1; s_right_din = 1'b1; step();
        check_eq("shl_lsb_sr1", p_dout, 4'b0001);
        s_left_din = 1'b0; step();
        check_eq("shl_next", p_dout, 4'b0010);

        // MSB is discarded on shift left, no rotation.
        select = 2'b11; p_din = 4'b1000; step();
        select = 2'b10; s_left_din = 1'b0; step();
        check_eq("shl_discard", p_dout, 4'b0000);

        // Async reset between edges.
        select = 2'b11; p_din = 4'b1111; step();
        check_eq("load_1111", p_dout, 4'b1111);
        #2 rst = 1'b0;
        #1 check_eq("async_clear", p_dout, 4'b0000);
        rst        = 1'b1;
        select     = 2'b10;
        s_left_din = 1'b1;
        step();
        check_eq("post_reset_shl", p_dout, 4'b0001);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
